// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// NOP encoding, FSM states and the if_id output tuple.
package if_fetch_pkg;

    localparam logic [4:0]  NOP_OP   = 5'b11111;
    localparam logic [15:0] NOP_WORD = {NOP_OP, 11'b0};

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] pc_addr4;
        logic [15:0] ins;
        logic        if_id_rst;
    } if_out_t;

endpackage

// File: rtl/if_fetch_slot.sv
// One buffered instruction: valid bit, its PC and the fetched word.
// Load wins over clear; clear only drops the valid bit.
module if_slot
    import if_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] pc_in,
    input  logic [15:0] ins_in,
    output logic        valid,
    output logic [15:0] pc,
    output logic [15:0] ins
);

    logic        valid_q, valid_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ins_q, ins_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            ins_d   = ins_in;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            ins_q   <= NOP_WORD;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign ins   = ins_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding fetch FSM, Cur/Pend
// buffering and the if_id drive mux with stall hold and squash.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0001
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    output logic        ImReq,
    output logic [15:0] ImAddr,
    input  logic        ImReady,
    input  logic        ImValid,
    input  logic [15:0] ImRdata,
    output logic [15:0] PcAddr4,
    output logic [15:0] InsOut,
    output logic        IfIdRst
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    if_out_t      prev_q, prev_d;

    logic        cur_valid, pend_valid;
    logic [15:0] cur_pc, cur_ins, pend_pc, pend_ins;
    logic        cur_load, cur_clear, pend_load, pend_clear;
    logic [15:0] cur_pc_in, cur_ins_in;

    logic    redirect, consume, word_ok, im_req;
    if_out_t pres, drv;

    assign redirect = BranchTaken & ~Stall;
    assign consume  = ~Stall;
    // A response is only kept if no squash is pending or happening now.
    assign word_ok  = (state_q == S_WAIT) & ImValid & ~drop_q & ~redirect;

    assign im_req = Rst & (state_q == S_REQ) & ~pend_valid & ~redirect;

    always_comb begin
        pres.pc_addr4  = cur_pc + PC_STEP;
        pres.ins       = cur_valid ? cur_ins : NOP_WORD;
        pres.if_id_rst = ~cur_valid;
        drv = pres;
        if (Stall) begin
            drv = prev_q;
        end else if (BranchTaken) begin
            drv.if_id_rst = 1'b1;
        end
    end

    always_comb begin
        cur_load   = 1'b0;
        cur_clear  = 1'b0;
        pend_load  = 1'b0;
        pend_clear = 1'b0;
        cur_pc_in  = pc_q;
        cur_ins_in = ImRdata;
        if (redirect) begin
            cur_clear  = 1'b1;
            pend_clear = 1'b1;
        end else if (word_ok) begin
            if (!cur_valid || consume) begin
                cur_load = 1'b1;
            end else begin
                pend_load = 1'b1;
            end
        end else if (consume) begin
            if (pend_valid) begin
                cur_load   = 1'b1;
                cur_pc_in  = pend_pc;
                cur_ins_in = pend_ins;
                pend_clear = 1'b1;
            end else begin
                cur_clear = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        prev_d  = drv;
        unique case (state_q)
            S_REQ: begin
                if (im_req && ImReady) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ImValid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (word_ok) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            default: state_d = S_REQ;
        endcase
        // The in-flight word belongs to the old path; mark it for discard.
        if (redirect) begin
            pc_d = BranchTarget;
            if (state_q == S_WAIT && !ImValid) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            prev_q  <= '{pc_addr4: RESET_PC + PC_STEP,
                         ins: NOP_WORD,
                         if_id_rst: 1'b1};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            prev_q  <= prev_d;
        end
    end

    if_slot #(.RESET_PC(RESET_PC)) u_cur (
        .clk    (Clk),
        .rst_n  (Rst),
        .load   (cur_load),
        .clear  (cur_clear),
        .pc_in  (cur_pc_in),
        .ins_in (cur_ins_in),
        .valid  (cur_valid),
        .pc     (cur_pc),
        .ins    (cur_ins)
    );

    if_slot #(.RESET_PC(RESET_PC)) u_pend (
        .clk    (Clk),
        .rst_n  (Rst),
        .load   (pend_load),
        .clear  (pend_clear),
        .pc_in  (pc_q),
        .ins_in (ImRdata),
        .valid  (pend_valid),
        .pc     (pend_pc),
        .ins    (pend_ins)
    );

    assign ImReq   = im_req;
    assign ImAddr  = pc_q;
    assign PcAddr4 = drv.pc_addr4;
    assign InsOut  = drv.ins;
    assign IfIdRst = drv.if_id_rst;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: program-order stream model, memory
// responder with latency, directed scenarios and a randomized phase.
module tb_if_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] STEP   = 16'h0001;
    localparam logic [15:0] NOP_W  = 16'hF800;
    localparam logic [32:0] RST_T  = {RST_PC + STEP, NOP_W, 1'b1};

    logic        Clk, Rst, Stall, BranchTaken, ImReq, ImReady, ImValid, IfIdRst;
    logic [15:0] BranchTarget, ImAddr, ImRdata, PcAddr4, InsOut;

    if_fetch #(.RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .ImReq(ImReq), .ImAddr(ImAddr),
        .ImReady(ImReady), .ImValid(ImValid), .ImRdata(ImRdata),
        .PcAddr4(PcAddr4), .InsOut(InsOut), .IfIdRst(IfIdRst)
    );

    typedef struct packed {
        logic [15:0] data;
        int          due;
        bit          stale;
    } rsp_t;

    typedef struct packed {
        logic [15:0] pc4;
        logic [15:0] ins;
    } exp_t;

    rsp_t        mq[$];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_cmp = 0, n_fail = 0;
    int          lat = 1;
    int          acc_cnt, cons_cnt, live_out, cons_total, last_cons;
    logic [15:0] base_pc, exp_next, hold_addr;
    logic [32:0] prev_t;
    bit          hold_v, tput_chk, run;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] memf(input logic [15:0] a);
        if (a < 16'd4) return 16'h1111 * (a + 16'd1);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input logic [32:0] act,
                       input logic [32:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic topup();
        exp_t e;
        while (exp_q.size() < 16) begin
            e.pc4 = exp_next + STEP;
            e.ins = memf(exp_next);
            exp_q.push_back(e);
            exp_next = exp_next + STEP;
        end
    endtask

    // The if_id stream restarts at b: b, b+1, b+2, ...
    task automatic flush(input logic [15:0] b);
        exp_q.delete();
        base_pc  = b;
        exp_next = b;
        acc_cnt  = 0;
        cons_cnt = 0;
        topup();
    endtask

    task automatic rst_checks();
        chk("rst_ifidrst", {32'd0, IfIdRst}, 33'd1);
        chk("rst_insout", {17'd0, InsOut}, {17'd0, NOP_W});
        chk("rst_pcaddr4", {17'd0, PcAddr4}, {17'd0, RST_PC + STEP});
        chk("rst_imreq", {32'd0, ImReq}, 33'd0);
    endtask

    task automatic step(input bit st, input bit br, input logic [15:0] tgt,
                        input bit rdy);
        @(posedge Clk);
        #1;
        ImValid = 1'b0;
        ImRdata = 16'($urandom);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            ImValid = 1'b1;
            ImRdata = mq[0].data;
            if (!mq[0].stale) live_out--;
            void'(mq.pop_front());
        end
        Stall        = st;
        BranchTaken  = br;
        BranchTarget = tgt;
        ImReady      = rdy;
        if (br && !st) flush(tgt);
        topup();
    endtask

    task automatic wait_inflight();
        int n;
        n = 0;
        while (mq.size() == 0 && n < 20) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            #6;
            n++;
        end
        if (mq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL inflight_timeout: no request accepted in %0d cycles", n);
        end
    endtask

    task automatic mid_reset();
        @(posedge Clk);
        #3;
        Rst = 1'b0;
        #1;
        rst_checks();
        foreach (mq[i]) mq[i].stale = 1'b1;
        live_out    = 0;
        Stall       = 1'b0;
        BranchTaken = 1'b0;
        ImValid     = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst     = 1'b1;
        ImReady = 1'b1;
        flush(RST_PC);
        // Old response shows up while the fresh request is being accepted.
        if (mq.size() > 0) begin
            ImValid = 1'b1;
            ImRdata = mq[0].data;
            void'(mq.pop_front());
        end
    endtask

    always @(negedge Clk) begin
        logic [32:0] cur_t;
        rsp_t        r;
        exp_t        e;
        cur_t = {PcAddr4, InsOut, IfIdRst};
        if (!Rst || !run) begin
            prev_t = RST_T;
            hold_v = 1'b0;
        end else begin
            if (hold_v && !(BranchTaken && !Stall))
                chk("req_hold", {16'd0, ImReq, ImAddr}, {16'd0, 1'b1, hold_addr});
            if (ImReq) begin
                chk("req_addr", {17'd0, ImAddr}, {17'd0, base_pc + 16'(acc_cnt)});
                chk("req_gate", {31'd0, live_out == 0, (acc_cnt - cons_cnt) <= 1},
                    33'd3);
                if (ImReady) begin
                    r.data  = memf(ImAddr);
                    r.due   = cyc + lat;
                    r.stale = 1'b0;
                    mq.push_back(r);
                    live_out++;
                    acc_cnt++;
                end
            end
            hold_v    = ImReq && !ImReady;
            hold_addr = ImAddr;
            if (Stall) begin
                chk("stall_hold", cur_t, prev_t);
            end else if (BranchTaken) begin
                chk("squash", {31'd0, IfIdRst, ImReq}, 33'd2);
            end else if (!IfIdRst) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL stream_extra: got %h with nothing expected", cur_t);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream", {1'b0, PcAddr4, InsOut}, {1'b0, e.pc4, e.ins});
                end
                cons_cnt++;
                cons_total++;
                if (tput_chk && last_cons >= 0)
                    chk("tput_gap", 33'(cyc - last_cons), 33'd2);
                last_cons = cyc;
            end
            prev_t = cur_t;
        end
    end

    initial begin
        bit          st, br, rdy;
        logic [15:0] tgt;
        Rst = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0;
        ImReady = 1'b0; ImValid = 1'b0; ImRdata = 16'h0;
        run = 1'b0; tput_chk = 1'b0; last_cons = -1;
        live_out = 0; cons_total = 0;
        flush(RST_PC);
        #2;
        rst_checks();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        ImReady = 1'b1;
        run = 1'b1;

        tput_chk = 1'b1;
        lat = 1;
        repeat (12) step(1'b0, 1'b0, 16'h0, 1'b1);
        tput_chk = 1'b0;

        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (8) step(1'b0, 1'b0, 16'h0, 1'b1);

        lat = 2;
        wait_inflight();
        step(1'b0, 1'b1, 16'h0040, 1'b1);
        repeat (10) step(1'b0, 1'b0, 16'h0, 1'b1);

        repeat (2) step(1'b1, 1'b1, 16'h0100, 1'b1);
        repeat (6) step(1'b0, 1'b0, 16'h0, 1'b1);

        lat = 1;
        repeat (4) step(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 16'h0, 1'b1);

        step(1'b0, 1'b1, 16'hFFFE, 1'b1);
        repeat (12) step(1'b0, 1'b0, 16'h0, 1'b1);

        lat = 3;
        wait_inflight();
        mid_reset();
        repeat (10) step(1'b0, 1'b0, 16'h0, 1'b1);

        repeat (3000) begin
            if (mq.size() == 0) lat = $urandom_range(1, 4);
            st  = ($urandom_range(0, 99) < 20);
            br  = ($urandom_range(0, 99) < 4);
            rdy = ($urandom_range(0, 99) < 75);
            tgt = 16'($urandom);
            step(st, br, tgt, rdy);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1);
        #6;
        chk("progress", {32'd0, cons_total >= 100}, 33'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
